// File: rtl/imem_dmem_port_arbiter_pkg.sv
// Shared types for the unified instruction/data memory port arbiter.
package cpu_mem_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;

endpackage

// File: rtl/imem_dmem_port_arbiter_select.sv
// Combinational winner pick: MEM has priority unless the fetch side has been
// passed over MAX_D_STREAK times in a row.
module mem_arb_select #(
  parameter int unsigned MAX_D_STREAK = 4,
  parameter int unsigned STREAK_W     = 3
) (
  input  logic                if_req,
  input  logic                d_req,
  input  logic [STREAK_W-1:0] streak,
  output logic                grant_if,
  output logic [STREAK_W-1:0] streak_nxt
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  always_comb begin
    grant_if   = if_req && (!d_req || (streak >= STREAK_MAX));
    streak_nxt = '0;
    // Only a MEM win over a waiting fetch counts towards starvation.
    if (!grant_if && if_req) begin
      streak_nxt = (streak >= STREAK_MAX) ? STREAK_MAX : streak + STREAK_W'(1);
    end
  end

endmodule

// File: rtl/imem_dmem_port_arbiter.sv
// Serialises IF and MEM stage requests onto one single-port memory, one
// transaction outstanding, with flushable fetches.
module imem_dmem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_flush,
  output logic                if_ack,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_ready,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int unsigned STREAK_W = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);

  arb_state_t            state_q, state_d;
  owner_t                owner_q;
  logic [ADDR_W-1:0]     addr_q;
  logic                  we_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W/8-1:0]   wstrb_q;
  logic [STREAK_W-1:0]   streak_q, streak_nxt;
  logic                  drop_q;
  logic [DATA_W-1:0]     if_rdata_q, d_rdata_q;
  logic                  grant_if;

  mem_arb_select #(
    .MAX_D_STREAK (MAX_D_STREAK),
    .STREAK_W     (STREAK_W)
  ) u_select (
    .if_req     (if_req),
    .d_req      (d_req),
    .streak     (streak_q),
    .grant_if   (grant_if),
    .streak_nxt (streak_nxt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (if_req || d_req) state_d = ISSUE;
      ISSUE:   if (mem_ready)       state_d = WAIT;
      WAIT:    if (mem_rvalid)      state_d = DONE;
      DONE:                         state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q    <= OWN_IF;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      streak_q   <= '0;
      drop_q     <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (state_q == IDLE && (if_req || d_req)) begin
        owner_q  <= grant_if ? OWN_IF : OWN_D;
        addr_q   <= grant_if ? if_addr : d_addr;
        we_q     <= grant_if ? 1'b0 : d_we;
        wdata_q  <= grant_if ? '0 : d_wdata;
        wstrb_q  <= grant_if ? '0 : d_wstrb;
        streak_q <= streak_nxt;
      end
      if (state_q == WAIT && mem_rvalid) begin
        if (owner_q == OWN_IF) if_rdata_q <= mem_rdata;
        else                   d_rdata_q  <= mem_rdata;
      end
      // The memory transaction always completes; a flush only hides the ack.
      if (state_q == DONE)
        drop_q <= 1'b0;
      else if (if_flush && owner_q == OWN_IF && state_q != IDLE)
        drop_q <= 1'b1;
    end
  end

  assign busy      = (state_q != IDLE);
  assign mem_req   = (state_q == ISSUE);
  assign mem_we    = mem_req && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  // A flush arriving in the DONE cycle itself must still suppress the ack.
  assign if_ack    = (state_q == DONE) && (owner_q == OWN_IF) && !drop_q && !if_flush;
  assign d_ack     = (state_q == DONE) && (owner_q == OWN_D);

endmodule

// File: tb/tb_imem_dmem_port_arbiter.sv
// Randomized bench for imem_dmem_port_arbiter against a transaction-level
// scoreboard and a word-array memory model.
module tb_imem_dmem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MAXS = 4;

  logic clk = 1'b0;
  logic reset;
  logic if_req, if_flush, if_ack, d_req, d_we, d_ack;
  logic [AW-1:0] if_addr, d_addr, mem_addr;
  logic [DW-1:0] if_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;
  logic [DW/8-1:0] d_wstrb, mem_wstrb;
  logic mem_req, mem_we, mem_ready, mem_rvalid, busy;

  imem_dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(MAXS)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // memory contents (word addressed, 16 words)
  logic [31:0] mem_m [16];

  // transaction in flight, as seen by the scoreboard
  bit          act, acc, rsp, own_if, drop_m;
  logic [31:0] addr_m, wdata_m;
  logic        we_m;
  logic [3:0]  wstrb_m;
  int unsigned d_wins;          // MEM wins in a row while a fetch waited
  logic [31:0] if_rd, d_rd;
  int unsigned resp_wait;
  logic [31:0] resp_data;
  bit          spur_v, if_got_ack, d_got_ack;
  int unsigned n_if_ack, n_d_ack, n_drop;

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = {26'b0, 4'($urandom_range(0, 15)), 2'b00};
    return a;
  endfunction

  task automatic model_reset();
    act = 0; acc = 0; rsp = 0; drop_m = 0; d_wins = 0;
    if_rd = '0; d_rd = '0; resp_wait = 0;
  endtask

  task automatic step();
    bit gi, done;
    int unsigned idx;
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
    if (resp_wait > 0) begin
      resp_wait--;
      if (resp_wait == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = resp_data;
      end
    end else if (spur_v) begin
      mem_rvalid = 1'b1;
    end
    #1;
    if (act && own_if && if_flush) drop_m = 1;
    done = act && acc && rsp;
    check_eq("busy", busy, act);
    check_eq("mem_req", mem_req, act && !acc);
    if (act && !acc) begin
      check_eq("mem_addr", mem_addr, addr_m);
      check_eq("mem_we", mem_we, we_m);
      check_eq("mem_wdata", mem_wdata, wdata_m);
      check_eq("mem_wstrb", mem_wstrb, wstrb_m);
    end
    check_eq("if_ack", if_ack, done && own_if && !drop_m);
    check_eq("d_ack", d_ack, done && !own_if);
    check_eq("if_rdata", if_rdata, if_rd);
    check_eq("d_rdata", d_rdata, d_rd);
    if_got_ack = if_ack;
    d_got_ack  = d_ack;
    if (if_ack) n_if_ack++;
    if (d_ack) n_d_ack++;
    if (done && own_if && drop_m) n_drop++;

    if (!act) begin
      if (if_req || d_req) begin
        gi = if_req && (!d_req || d_wins >= MAXS);
        if (gi) d_wins = 0;
        else if (if_req) d_wins = (d_wins >= MAXS) ? MAXS : d_wins + 1;
        else d_wins = 0;
        act = 1; acc = 0; rsp = 0; drop_m = 0; own_if = gi;
        addr_m  = gi ? if_addr : d_addr;
        we_m    = gi ? 1'b0 : d_we;
        wdata_m = gi ? '0 : d_wdata;
        wstrb_m = gi ? '0 : d_wstrb;
      end
    end else if (!acc) begin
      if (mem_ready) begin
        acc = 1;
        idx = addr_m[5:2];
        resp_data = mem_m[idx];
        if (we_m)
          for (int b = 0; b < 4; b++)
            if (wstrb_m[b]) mem_m[idx][8*b +: 8] = wdata_m[8*b +: 8];
        resp_wait = $urandom_range(1, 3);
      end
    end else if (!rsp) begin
      if (mem_rvalid) begin
        rsp = 1;
        if (own_if) if_rd = mem_rdata;
        else        d_rd  = mem_rdata;
      end
    end else begin
      act = 0;
    end
    @(negedge clk);
  endtask

  task automatic gen_random();
    if (if_got_ack || if_flush || !if_req) begin
      if_req  = ($urandom % 4) != 0;
      if_addr = rnd_addr();
    end
    if_flush = ($urandom % 12) == 0;
    if (d_got_ack || !d_req) begin
      d_req   = ($urandom % 5) != 0;
      d_we    = 1'($urandom);
      d_addr  = rnd_addr();
      d_wdata = $urandom;
      d_wstrb = 4'($urandom);
    end
    mem_ready = ($urandom % 3) != 0;
    spur_v = (resp_wait == 0) && (!act || !acc) && (($urandom % 8) == 0);
  endtask

  task automatic quiet_inputs();
    if_req = 0; if_flush = 0; if_addr = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    mem_ready = 0; spur_v = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_mem_req"}, mem_req, 0);
    check_eq({tag, "_mem_we"}, mem_we, 0);
    check_eq({tag, "_mem_addr"}, mem_addr, 0);
    check_eq({tag, "_mem_wdata"}, mem_wdata, 0);
    check_eq({tag, "_mem_wstrb"}, mem_wstrb, 0);
    check_eq({tag, "_if_ack"}, if_ack, 0);
    check_eq({tag, "_d_ack"}, d_ack, 0);
    check_eq({tag, "_if_rdata"}, if_rdata, 0);
    check_eq({tag, "_d_rdata"}, d_rdata, 0);
  endtask

  initial begin
    bit seen;
    for (int i = 0; i < 16; i++) mem_m[i] = $urandom;
    mem_m[0] = 32'h00A0_0093;
    quiet_inputs();
    mem_rvalid = 0; mem_rdata = '0;
    reset = 1'b1;
    model_reset();
    n_if_ack = 0; n_d_ack = 0; n_drop = 0;
    if_got_ack = 0; d_got_ack = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("rst");
    reset = 1'b0;

    // single fetch of address 0, memory always ready
    if_req = 1; if_addr = '0; mem_ready = 1;
    for (int c = 0; c < 4; c++) begin
      step();
      if (if_got_ack) if_req = 0;
    end
    check_eq("first_fetch_ack_count", n_if_ack, 1);
    check_eq("first_fetch_data", if_rdata, 32'h00A0_0093);

    for (int c = 0; c < 4000; c++) begin
      gen_random();
      step();
    end
    check_eq("saw_if_acks", n_if_ack > 50, 1);
    check_eq("saw_d_acks", n_d_ack > 50, 1);
    check_eq("saw_drops", n_drop > 0, 1);

    // drain, then reset in the middle of a WAIT
    quiet_inputs();
    mem_ready = 1;
    for (int c = 0; c < 20 && act; c++) step();
    check_eq("drained", act, 0);
    d_req = 1; d_we = 0; d_addr = 32'h8;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      step();
      seen = act && acc;
    end
    check_eq("reached_wait", seen, 1);
    d_req = 0;
    #2 reset = 1'b1;
    #1 check_all_zero("async_rst");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    spur_v = 1;
    step();
    spur_v = 0;
    step();
    d_req = 1; d_we = 0; d_addr = 32'hC;
    seen = 0;
    for (int c = 0; c < 12 && !seen; c++) begin
      step();
      if (d_got_ack) begin
        seen = 1;
        d_req = 0;
      end
    end
    check_eq("fresh_d_ack", seen, 1);
    check_eq("fresh_d_data", d_rdata, mem_m[3]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_dmem_port_arbiter.md
Name: imem_dmem_port_arbiter

Overview:
- Shares one unified single-port instruction/data memory between the pipeline's fetch stage (IF) and its memory stage (MEM).
- Serialises requests and keeps exactly one transaction outstanding.
- Gives MEM priority, with a fetch anti-starvation limit.
- Lets IF drop an in-flight fetch on branch flush without disturbing the memory protocol.

Parameters:
- ADDR_W, 32, address width for both requesters and the memory port.
- DATA_W, 32, data width.
- MAX_D_STREAK, 4, consecutive MEM grants allowed while IF is waiting; the next grant is forced to IF.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held until if_ack or if_flush.
- if_addr  in  ADDR_W  fetch address; stable while if_req is high.
- if_flush  in  1  one-cycle pulse; abandon the current fetch.
- if_ack  out  1  one-cycle pulse; if_rdata is valid.
- if_rdata  out  DATA_W  fetched instruction.
- d_req  in  1  load/store request; held until d_ack.
- d_we  in  1  1 = store.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_wstrb  in  DATA_W/8  byte enables.
- d_ack  out  1  one-cycle pulse; d_rdata is valid (loads).
- d_rdata  out  DATA_W  load data.
- mem_req  out  1  memory request.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  write data.
- mem_wstrb  out  DATA_W/8  byte enables.
- mem_ready  in  1  memory accepts the request this cycle when mem_req is high.
- mem_rvalid  in  1  response (read data or write completion); earliest one cycle after acceptance.
- mem_rdata  in  DATA_W  read data.
- busy  out  1  arbiter is not in IDLE.

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE, streak = 0, drop = 0.
  - All outputs 0, including rdata registers.
  - Reset during ISSUE/WAIT aborts silently; a stale mem_rvalid arriving later in IDLE is ignored.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If if_req or d_req is high, pick the winner and latch owner, addr, we, wdata and wstrb; go to ISSUE.
  - For an IF winner, latched we = 0 and wstrb = 0.
- ISSUE:
  - mem_req = 1 with the latched fields; outputs are registered and stable while waiting.
  - On mem_ready, go to WAIT; mem_req deasserts the next cycle.
- WAIT:
  - On mem_rvalid, latch mem_rdata into the owner's rdata register and go to DONE.
  - mem_rvalid is ignored in IDLE and ISSUE.
- DONE:
  - Pulse the owner's ack for exactly one cycle unless owner = IF and drop = 1.
  - Always return to IDLE; clear drop.
- Arbitration rule:
  - Grant IF if if_req && (!d_req || streak >= MAX_D_STREAK); otherwise grant MEM.
  - An MEM grant while if_req is high increments streak, saturating at MAX_D_STREAK.
  - An IF grant, or an MEM grant with if_req low, clears streak to 0.
- Flush:
  - if_flush while owner = IF in ISSUE, WAIT or DONE sets drop. The memory transaction still completes and if_ack is suppressed.
  - if_flush in IDLE, or while owner = MEM, has no effect.
  - MEM transactions are never dropped.
- Back-to-back operation:
  - The requester may keep req high after ack with new address/data; these are sampled in the following IDLE cycle.
  - No idle bubble is added beyond the IDLE cycle itself.
- Latency:
  - With mem_ready = 1 in ISSUE and mem_rvalid one cycle after acceptance, ack occurs 3 cycles after the IDLE sample cycle.
  - Throughput is one transaction per 4 cycles.
- rdata registers hold their value until the next completion for the same owner.
- busy = (state != IDLE).

Decomposition:
- Package cpu_mem_pkg holds:
  - state enum {IDLE, ISSUE, WAIT, DONE};
  - owner enum {OWN_IF, OWN_D};
  - default ADDR_W/DATA_W constants.
- One sub-module, mem_arb_select: a combinational winner pick plus the next streak value.
  - Inputs: if_req, d_req, streak.
  - Outputs: grant_if, streak_nxt.
  - The top level owns all registers.

Test Plan:
1. Single fetch: if_addr=0x0, memory returns 0x00A00093, mem_ready=1, rvalid one cycle after acceptance -> if_ack one cycle, 3 cycles after the IDLE sample; if_rdata=0x00A00093; d_ack never high.
2. Simultaneous requests: if_req and d_req (load 0x100 -> 0x0000000F) in the same cycle -> MEM served first (d_rdata=0x0F), then IF; mem_addr sequence is 0x100, 0x0.
3. Starvation: d_req held high for 6 back-to-back stores with if_req high -> grant order D,D,D,D,IF,D; streak resets after the IF grant.
4. Flush: pulse if_flush while an IF transaction is in WAIT -> mem_rvalid consumed, if_ack stays 0, next IDLE accepts a new if_addr=0x20 normally.
5. Backpressure: mem_ready low for 5 cycles in ISSUE -> mem_req, mem_addr and mem_wdata stay stable throughout; a store with d_wstrb=4'b0011 is accepted on the ready cycle and acked after rvalid.
6. Reset mid-WAIT: assert reset between clock edges -> all outputs 0 immediately; a later mem_rvalid produces no ack; after release, a fresh d_req completes normally.
